frame_demux: RTL and testbench
==============================

Name: frame_demux

Overview:
- Parametrised successor of the network-layer RX frame splitter.
- Accepts a typed byte/word stream from the MAC RX path and routes each whole frame to one of NUM_CH downstream channels (ARP, UDP, ICMP, ...) with full valid/ready backpressure.
- Discards frames with no recognised type, and truncates frames longer than MAX_BEATS.
- Sits between the MAC RX stream and the per-protocol RX engines.

Parameters:
- DATA_W, 8: data beat width in bits.
- NUM_CH, 3: number of output channels; the channel index equals the type bit index.
- MAX_BEATS, 1536: maximum forwarded beats per frame. Range 2..65535.
- CNT_W, 16: width of each statistics counter.

Ports:
- logic_clk  in  1  single clock for the whole block.
- logic_rstn  in  1  asynchronous, active-low reset.
- net_rdata_in  in  DATA_W  input beat data.
- net_rvalid_in  in  1  input beat valid.
- net_rready_out  out  1  input beat ready.
- net_rlast_in  in  1  last beat of the frame.
- net_rtype_in  in  NUM_CH  one-hot frame type; sampled on the first beat only.
- ch_rdata_out  out  NUM_CH*DATA_W  per-channel data. All slices carry the same register (broadcast).
- ch_rvalid_out  out  NUM_CH  per-channel valid; at most one bit is set.
- ch_rready_in  in  NUM_CH  per-channel ready.
- ch_rlast_out  out  NUM_CH  per-channel last.
- drop_pulse_out  out  1  one-cycle pulse when an untyped frame finishes being discarded.
- trunc_pulse_out  out  1  one-cycle pulse when a frame is truncated.
- frame_cnt_out  out  NUM_CH*CNT_W  forwarded-frame count per channel. Present only with FRAME_DEMUX_STATS_EN.
- drop_cnt_out  out  CNT_W  dropped-plus-truncated frame count. Present only with FRAME_DEMUX_STATS_EN.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state goes to IDLE; the output register is emptied.
  - All outputs are 0, including net_rready_out and the counters.
- Handshake: a beat transfers when valid && ready, on either side.
  - ch_rvalid_out is never withdrawn before its ready.
  - Output data and last are held stable while stalled.
- Output stage: one-entry pipeline register. Latency from input accept to ch_rvalid_out is 1 cycle.
- Selection: sel = lowest set bit of net_rtype_in, taken on the first beat accepted in IDLE. sel is held in a register for the rest of the frame.
- State machine:
  - IDLE:
    - net_rready_out = slot_free, where slot_free = !out_valid || ch_rready_in[cur_sel].
    - On accept with type != 0: the beat is loaded, beat_cnt is set to 1, and the next state is FWD. If the beat also has last, the next state stays IDLE.
    - On accept with type == 0: net_rready_out is forced to 1, the beat is discarded, and the next state is DROP. If the beat also has last, the next state stays IDLE and drop_pulse_out fires.
  - FWD:
    - net_rready_out = slot_free. Each accept loads the register and increments beat_cnt.
    - An accepted beat with last returns the state to IDLE.
    - An accepted beat with beat_cnt == MAX_BEATS-1 and no last is loaded with the last flag forced to 1. The next state is TRUNC and trunc_pulse_out fires.
  - DROP and TRUNC:
    - net_rready_out = 1; beats are discarded.
    - An accepted last returns the state to IDLE.
    - On DROP exit, drop_pulse_out fires.
- Back-to-back frames: a frame's first beat may be accepted the cycle after the previous frame's last beat was accepted. No idle gap is required.
- Output stall: a register can fill while its channel is stalled, including on the last beat of a frame. net_rready_out then stays low until that channel's ready, even if the next frame targets a different channel. This guarantees frame ordering across channels.
- A frame of exactly MAX_BEATS beats whose last beat arrives at the limit is not truncated.
- net_rtype_in is ignored on every beat except the first.
- A reset asserted mid-frame returns the block to IDLE. Upstream is reset on the same reset.

Optional Feature:
- Macro: FRAME_DEMUX_STATS_EN.
- Defined:
  - frame_cnt_out[ch] increments when a last beat is handed off on ch, including forced last.
  - drop_cnt_out increments on each drop or truncation pulse.
  - Counters saturate at all-ones and are cleared by reset.
- Undefined: the counter ports and logic are absent. All other behaviour is identical.

Decomposition:
- Package frame_demux_pkg holds:
  - the state enum (IDLE, FWD, DROP, TRUNC);
  - the type bit-index constants TYPE_ARP=0, TYPE_UDP=1, TYPE_ICMP=2;
  - a lowest-set-bit priority function.
- One natural sub-module, stream_reg_slice: the 1-entry output register with valid/ready, parametrised by DATA_W.

Test Plan:
- ARP, type 3'b001, 42 beats, all readies high: 42 beats appear on ch0 at 1-cycle latency with last on beat 42. ch1 and ch2 valid stay 0.
- UDP 10 beats, ch_rready_in[1] toggled 1010...: no beat lost or duplicated. Data is stable while stalled; net_rready_out drops while the slot is full and unconsumed.
- Type 3'b000, 8 beats: net_rready_out is 1 throughout, no channel valid rises, and drop_pulse_out fires once after beat 8. With FRAME_DEMUX_STATS_EN, drop_cnt_out = 1.
- MAX_BEATS=16, UDP frame of 20 beats: 16 beats are forwarded with last on beat 16 and trunc_pulse_out fires once. Beats 17-20 are accepted and discarded. A 16-beat frame is not truncated.
- Back-to-back frames UDP(4) then ARP(4) with ch1 stalled 5 cycles: ARP beat 1 is not accepted until UDP's last is consumed, and the ARP frame then follows intact.
- Assert logic_rstn low mid-FWD, asynchronously between clock edges: all outputs are 0 immediately. After release, the next frame with type 3'b100 routes correctly to ch2.

Source files
------------

// File: rtl/frame_demux_pkg.sv
// frame_demux_pkg: shared types and helpers for the frame demultiplexer.
// Contents: FSM state enum, protocol type bit-index constants and a
// lowest-set-bit priority function used to pick the output channel.
package frame_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    DROP  = 2'd2,
    TRUNC = 2'd3
  } state_e;

  localparam int TYPE_ARP  = 0;
  localparam int TYPE_UDP  = 1;
  localparam int TYPE_ICMP = 2;

  // Widest type vector the priority function handles.
  localparam int PRIO_W = 32;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [4:0] lowest_set(input logic [PRIO_W-1:0] v);
    lowest_set = '0;
    for (int i = PRIO_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/frame_demux_if.sv
// frame_demux_if: stream bundle between the MAC RX path, the demux and the
// per-protocol RX engines.
// Signals: net_r* is the typed input stream (data/valid/ready/last/type),
// ch_r* are the NUM_CH output channels (data broadcast, one-hot valid).
// Modports: slave = the demux view, master = the surrounding environment.
interface frame_demux_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3
);

  logic [DATA_W-1:0]        net_rdata_in;
  logic                     net_rvalid_in;
  logic                     net_rready_out;
  logic                     net_rlast_in;
  logic [NUM_CH-1:0]        net_rtype_in;
  logic [NUM_CH*DATA_W-1:0] ch_rdata_out;
  logic [NUM_CH-1:0]        ch_rvalid_out;
  logic [NUM_CH-1:0]        ch_rready_in;
  logic [NUM_CH-1:0]        ch_rlast_out;

  modport slave (
    input  net_rdata_in, net_rvalid_in, net_rlast_in, net_rtype_in, ch_rready_in,
    output net_rready_out, ch_rdata_out, ch_rvalid_out, ch_rlast_out
  );

  modport master (
    output net_rdata_in, net_rvalid_in, net_rlast_in, net_rtype_in, ch_rready_in,
    input  net_rready_out, ch_rdata_out, ch_rvalid_out, ch_rlast_out
  );

endinterface

// File: rtl/frame_demux_stream_reg_slice.sv
// stream_reg_slice: one-entry valid/ready pipeline register.
// Ports: logic_clk, logic_rstn (async active-low), in_valid_i/in_ready_o/
// in_data_i/in_last_i (load side), out_valid_o/out_ready_i/out_data_o/
// out_last_o (drain side). Accepts a new entry in the same cycle the held
// one drains, so a continuously ready sink sees full throughput.
module stream_reg_slice #(
  parameter int DATA_W = 8
) (
  input  logic              logic_clk,
  input  logic              logic_rstn,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  assign in_ready_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
      last_d  = in_last_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge logic_clk or negedge logic_rstn) begin
    if (!logic_rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/frame_demux.sv
// frame_demux: routes each whole frame of the MAC RX stream to one of NUM_CH
// protocol channels, chosen by the lowest set bit of the frame type taken on
// its first beat. Untyped frames are discarded; frames longer than MAX_BEATS
// are cut with a forced last and the tail is discarded.
// Ports: logic_clk, logic_rstn (async active-low), bus (frame_demux_if.slave),
// drop_pulse_out, trunc_pulse_out (one-cycle event pulses), and with
// FRAME_DEMUX_STATS_EN defined: frame_cnt_out (per-channel forwarded frames),
// drop_cnt_out (dropped plus truncated frames), both saturating.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// FWD   | forwarding a typed frame to channel sel_q
// DROP  | discarding an untyped frame up to its last beat
// TRUNC | discarding the tail of a frame cut at MAX_BEATS
module frame_demux #(
  parameter int DATA_W    = 8,
  parameter int NUM_CH    = 3,
  parameter int MAX_BEATS = 1536,
  parameter int CNT_W     = 16
) (
  input  logic                    logic_clk,
  input  logic                    logic_rstn,
  frame_demux_if.slave            bus,
  output logic                    drop_pulse_out,
  output logic                    trunc_pulse_out
`ifdef FRAME_DEMUX_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] frame_cnt_out,
  output logic [CNT_W-1:0]        drop_cnt_out
`endif
);

  import frame_demux_pkg::*;

  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BCNT_W = $clog2(MAX_BEATS + 1);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                rdy_en_q;
  logic                drop_pulse_q, drop_pulse_d;
  logic                trunc_pulse_q, trunc_pulse_d;

  logic                slot_free;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                load;
  logic                load_last;
  logic                rready_raw;
  logic                accept;
  logic                type_none;
  logic                at_limit;

  assign type_none = (bus.net_rtype_in == '0);
  assign at_limit  = (beat_cnt_q == BCNT_W'(MAX_BEATS - 1));
  // The held beat always belongs to sel_q, so the next frame (whatever its
  // channel) waits behind it; this keeps frames ordered across channels.
  assign out_ready = bus.ch_rready_in[sel_q];

  always_comb begin
    rready_raw = 1'b0;
    case (state_q)
      IDLE:        rready_raw = type_none ? 1'b1 : slot_free;
      FWD:         rready_raw = slot_free;
      DROP, TRUNC: rready_raw = 1'b1;
      default:     rready_raw = 1'b0;
    endcase
  end

  // Ready is held low until the first clock after reset release.
  assign bus.net_rready_out = rdy_en_q && rready_raw;
  assign accept             = bus.net_rvalid_in && bus.net_rready_out;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    beat_cnt_d    = beat_cnt_q;
    load          = 1'b0;
    load_last     = bus.net_rlast_in;
    drop_pulse_d  = 1'b0;
    trunc_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (type_none) begin
            if (bus.net_rlast_in) drop_pulse_d = 1'b1;
            else                  state_d      = DROP;
          end else begin
            load       = 1'b1;
            sel_d      = SEL_W'(lowest_set(PRIO_W'(bus.net_rtype_in)));
            beat_cnt_d = BCNT_W'(1);
            if (!bus.net_rlast_in) state_d = FWD;
          end
        end
      end
      FWD: begin
        if (accept) begin
          load       = 1'b1;
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          if (bus.net_rlast_in) begin
            state_d = IDLE;
          end else if (at_limit) begin
            load_last     = 1'b1;
            trunc_pulse_d = 1'b1;
            state_d       = TRUNC;
          end
        end
      end
      DROP: begin
        if (accept && bus.net_rlast_in) begin
          drop_pulse_d = 1'b1;
          state_d      = IDLE;
        end
      end
      TRUNC: begin
        if (accept && bus.net_rlast_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge logic_clk or negedge logic_rstn) begin
    if (!logic_rstn) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      beat_cnt_q    <= '0;
      rdy_en_q      <= 1'b0;
      drop_pulse_q  <= 1'b0;
      trunc_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      beat_cnt_q    <= beat_cnt_d;
      rdy_en_q      <= 1'b1;
      drop_pulse_q  <= drop_pulse_d;
      trunc_pulse_q <= trunc_pulse_d;
    end
  end

  stream_reg_slice #(.DATA_W(DATA_W)) u_out_reg (
    .logic_clk   (logic_clk),
    .logic_rstn  (logic_rstn),
    .in_valid_i  (load),
    .in_ready_o  (slot_free),
    .in_data_i   (bus.net_rdata_in),
    .in_last_i   (load_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last)
  );

  always_comb begin
    bus.ch_rvalid_out        = '0;
    bus.ch_rlast_out         = '0;
    bus.ch_rvalid_out[sel_q] = out_valid;
    bus.ch_rlast_out[sel_q]  = out_valid && out_last;
  end

  assign bus.ch_rdata_out = {NUM_CH{out_data}};
  assign drop_pulse_out   = drop_pulse_q;
  assign trunc_pulse_out  = trunc_pulse_q;

`ifdef FRAME_DEMUX_STATS_EN
  logic [NUM_CH-1:0][CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0]             drop_cnt_q;

  always_ff @(posedge logic_clk or negedge logic_rstn) begin
    if (!logic_rstn) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (out_valid && out_ready && out_last && (sel_q == SEL_W'(c)) &&
            (frame_cnt_q[c] != '1)) begin
          frame_cnt_q[c] <= frame_cnt_q[c] + CNT_W'(1);
        end
      end
      if ((drop_pulse_d || trunc_pulse_d) && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  assign frame_cnt_out = frame_cnt_q;
  assign drop_cnt_out  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_frame_demux.sv
// tb_frame_demux: randomized and directed stimulus for frame_demux, checked
// every cycle against a frame-level reference model (expected-beat queue,
// discard/truncate rules, expected ready and pulses).
module tb_frame_demux;

  localparam int DW   = 8;
  localparam int NCH  = 3;
  localparam int MAXB = 48;
  localparam int CW   = 16;

  logic logic_clk = 1'b0;
  logic logic_rstn = 1'b0;
  logic drop_pulse_out, trunc_pulse_out;
`ifdef FRAME_DEMUX_STATS_EN
  logic [NCH*CW-1:0] frame_cnt_out;
  logic [CW-1:0]     drop_cnt_out;
`endif

  frame_demux_if #(.DATA_W(DW), .NUM_CH(NCH)) bus ();

  frame_demux #(.DATA_W(DW), .NUM_CH(NCH), .MAX_BEATS(MAXB), .CNT_W(CW)) dut (
    .logic_clk      (logic_clk),
    .logic_rstn     (logic_rstn),
    .bus            (bus.slave),
    .drop_pulse_out (drop_pulse_out),
    .trunc_pulse_out(trunc_pulse_out)
`ifdef FRAME_DEMUX_STATS_EN
    ,
    .frame_cnt_out  (frame_cnt_out),
    .drop_cnt_out   (drop_cnt_out)
`endif
  );

  always #5 logic_clk = ~logic_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            ch;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t q[$];
  bit    m_infrm, m_disc, m_disc_drop;
  int    m_idx, m_ch;
  bit    pend_drop, pend_trunc;
  int    m_fcnt[NCH];
  int    m_dcnt;
  int    hs_cnt[NCH], last_seen[NCH];
  int    drop_seen, trunc_seen, rdy_low;

  function automatic int low_bit(input logic [NCH-1:0] t);
    low_bit = 0;
    for (int i = NCH - 1; i >= 0; i--) if (t[i]) low_bit = i;
  endfunction

  always @(negedge logic_clk) begin
    bit slot_free, exp_rdy, fl;
    if (!logic_rstn) begin
      chk("rst_rready", 64'(bus.net_rready_out), 64'(0));
      chk("rst_valid", 64'(bus.ch_rvalid_out), 64'(0));
      chk("rst_pulses", 64'({drop_pulse_out, trunc_pulse_out}), 64'(0));
      q.delete();
      m_infrm = 0; m_disc = 0; pend_drop = 0; pend_trunc = 0;
      for (int c = 0; c < NCH; c++) m_fcnt[c] = 0;
      m_dcnt = 0;
    end else begin
      if (q.size() == 0) begin
        chk("valid_idle", 64'(bus.ch_rvalid_out), 64'(0));
      end else begin
        chk("valid", 64'(bus.ch_rvalid_out), 64'(1) << q[0].ch);
        chk("data", 64'(bus.ch_rdata_out[q[0].ch*DW +: DW]), 64'(q[0].d));
        chk("last", 64'(bus.ch_rlast_out), q[0].l ? (64'(1) << q[0].ch) : 64'(0));
      end
      chk("drop_pulse", 64'(drop_pulse_out), 64'(pend_drop));
      chk("trunc_pulse", 64'(trunc_pulse_out), 64'(pend_trunc));
`ifdef FRAME_DEMUX_STATS_EN
      for (int c = 0; c < NCH; c++)
        chk("frame_cnt", 64'(frame_cnt_out[c*CW +: CW]), 64'(m_fcnt[c]));
      chk("drop_cnt", 64'(drop_cnt_out), 64'(m_dcnt));
`endif
      drop_seen  += int'(drop_pulse_out);
      trunc_seen += int'(trunc_pulse_out);
      pend_drop  = 0;
      pend_trunc = 0;

      slot_free = (q.size() == 0) || bus.ch_rready_in[q[0].ch];
      exp_rdy   = m_disc || (!m_infrm && bus.net_rtype_in == '0) || slot_free;
      chk("net_rready", 64'(bus.net_rready_out), 64'(exp_rdy));
      if (bus.net_rvalid_in && !bus.net_rready_out) rdy_low++;

      if (q.size() != 0 && bus.ch_rready_in[q[0].ch]) begin
        hs_cnt[q[0].ch]++;
        if (q[0].l) begin
          last_seen[q[0].ch]++;
          if (m_fcnt[q[0].ch] < (1 << CW) - 1) m_fcnt[q[0].ch]++;
        end
        void'(q.pop_front());
      end

      if (bus.net_rvalid_in && bus.net_rready_out) begin
        if (m_disc) begin
          if (bus.net_rlast_in) begin
            m_disc = 0;
            if (m_disc_drop) begin pend_drop = 1; m_dcnt++; end
          end
        end else if (!m_infrm) begin
          if (bus.net_rtype_in == '0) begin
            if (bus.net_rlast_in) begin pend_drop = 1; m_dcnt++; end
            else begin m_disc = 1; m_disc_drop = 1; end
          end else begin
            m_ch  = low_bit(bus.net_rtype_in);
            m_idx = 1;
            q.push_back('{m_ch, bus.net_rdata_in, bus.net_rlast_in});
            if (!bus.net_rlast_in) m_infrm = 1;
          end
        end else begin
          m_idx++;
          fl = bus.net_rlast_in || (m_idx == MAXB);
          q.push_back('{m_ch, bus.net_rdata_in, fl});
          if (fl) m_infrm = 0;
          if (!bus.net_rlast_in && m_idx == MAXB) begin
            m_disc = 1; m_disc_drop = 0; pend_trunc = 1; m_dcnt++;
          end
        end
      end
    end
  end

  // ---------------- channel ready driver ----------------
  int rdy_mode = 0;
  int tgl = 0;
  int stall_left = 0;
  bit stall_done = 0;

  always @(posedge logic_clk) begin
    logic [NCH-1:0] r;
    #1;
    r = '1;
    tgl++;
    case (rdy_mode)
      1: for (int c = 0; c < NCH; c++) r[c] = ($urandom_range(99) < 70);
      2: r[1] = tgl[0];
      3: begin
        if (!stall_done && stall_left == 0 && bus.ch_rvalid_out[1] && bus.ch_rlast_out[1])
          stall_left = 5;
        if (stall_left > 0) begin
          r[1] = 1'b0;
          stall_left--;
          if (stall_left == 0) stall_done = 1;
        end
      end
      4: r[1] = 1'b0;
      default: r = '1;
    endcase
    bus.ch_rready_in = r;
  end

  // ---------------- stimulus ----------------
  task automatic sync();
    @(posedge logic_clk);
    #1;
  endtask

  // Leaves valid high after the final beat so frames can run back to back.
  task automatic send_frame(input logic [NCH-1:0] ftype, input int nbeats,
                            input int gap_pct, input bit with_last);
    int w;
    for (int b = 0; b < nbeats; b++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.net_rvalid_in = 1'b0;
        bus.net_rtype_in  = NCH'($urandom);
        sync();
      end
      bus.net_rvalid_in = 1'b1;
      bus.net_rdata_in  = DW'($urandom);
      bus.net_rlast_in  = with_last && (b == nbeats - 1);
      bus.net_rtype_in  = (b == 0) ? ftype : NCH'($urandom);
      w = 0;
      @(negedge logic_clk);
      while (!bus.net_rready_out && w < 200) begin
        w++;
        @(negedge logic_clk);
      end
      chk("accept_wait", 64'(w < 200), 64'(1));
      sync();
    end
  endtask

  task automatic idle_in();
    bus.net_rvalid_in = 1'b0;
    bus.net_rlast_in  = 1'b0;
    bus.net_rtype_in  = '0;
  endtask

  task automatic drain();
    int w = 0;
    idle_in();
    while (q.size() != 0 && w < 500) begin
      w++;
      @(negedge logic_clk);
    end
    chk("drain", 64'(q.size()), 64'(0));
    repeat (3) @(negedge logic_clk);
    sync();
  endtask

  task automatic clr();
    for (int c = 0; c < NCH; c++) begin hs_cnt[c] = 0; last_seen[c] = 0; end
    drop_seen = 0; trunc_seen = 0; rdy_low = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.net_rdata_in  = '0;
    bus.ch_rready_in  = '1;
    idle_in();
    clr();
    repeat (3) @(negedge logic_clk);
    #1 logic_rstn = 1'b1;
    @(negedge logic_clk);
    chk("ready_after_rst", 64'(bus.net_rready_out), 64'(1));
    sync();

    // ARP 42 beats, all ready
    clr(); rdy_mode = 0;
    send_frame(3'b001, 42, 0, 1); drain();
    chk("arp_ch0_beats", 64'(hs_cnt[0]), 64'(42));
    chk("arp_ch1_beats", 64'(hs_cnt[1]), 64'(0));
    chk("arp_ch2_beats", 64'(hs_cnt[2]), 64'(0));
    chk("arp_lasts", 64'(last_seen[0]), 64'(1));

    // UDP 10 beats, ch1 ready toggling
    clr(); rdy_mode = 2;
    send_frame(3'b010, 10, 0, 1); drain();
    chk("udp_ch1_beats", 64'(hs_cnt[1]), 64'(10));
    chk("udp_lasts", 64'(last_seen[1]), 64'(1));
    chk("udp_stall_seen", 64'(rdy_low > 0), 64'(1));

    // untyped frame, 8 beats
    clr(); rdy_mode = 0;
    send_frame(3'b000, 8, 0, 1); drain();
    chk("drop_beats", 64'(hs_cnt[0] + hs_cnt[1] + hs_cnt[2]), 64'(0));
    chk("drop_pulses", 64'(drop_seen), 64'(1));
    chk("drop_no_stall", 64'(rdy_low), 64'(0));
`ifdef FRAME_DEMUX_STATS_EN
    chk("drop_cnt_lit", 64'(drop_cnt_out), 64'(1));
`endif

    // over-long frame is cut at MAXB
    clr();
    send_frame(3'b010, MAXB + 4, 10, 1); drain();
    chk("trunc_beats", 64'(hs_cnt[1]), 64'(MAXB));
    chk("trunc_lasts", 64'(last_seen[1]), 64'(1));
    chk("trunc_pulses", 64'(trunc_seen), 64'(1));

    // exactly MAXB beats is not truncated
    clr();
    send_frame(3'b010, MAXB, 0, 1); drain();
    chk("exact_beats", 64'(hs_cnt[1]), 64'(MAXB));
    chk("exact_no_trunc", 64'(trunc_seen), 64'(0));

    // back to back UDP(4) then ARP(4) with ch1 stalled on UDP's last
    clr(); stall_done = 0; stall_left = 0; rdy_mode = 3;
    send_frame(3'b010, 4, 0, 1);
    send_frame(3'b001, 4, 0, 1); drain();
    chk("b2b_udp_beats", 64'(hs_cnt[1]), 64'(4));
    chk("b2b_arp_beats", 64'(hs_cnt[0]), 64'(4));
    chk("b2b_stall_seen", 64'(rdy_low >= 4), 64'(1));

    // random traffic with random readies and bubbles
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      send_frame(NCH'($urandom_range(7)), $urandom_range(1, MAXB + 6), 20, 1);
      if ($urandom_range(1)) idle_in();
    end
    drain();

    // reset in the middle of a stalled UDP frame
    clr(); rdy_mode = 4;
    send_frame(3'b010, 1, 0, 0);
    idle_in();
    repeat (2) sync();
    chk("pre_rst_valid", 64'(bus.ch_rvalid_out), 64'(3'b010));
    @(posedge logic_clk);
    #3 logic_rstn = 1'b0;
    #1;
    chk("async_rst_rready", 64'(bus.net_rready_out), 64'(0));
    chk("async_rst_valid", 64'(bus.ch_rvalid_out), 64'(0));
    chk("async_rst_data", 64'(bus.ch_rdata_out), 64'(0));
    chk("async_rst_last", 64'(bus.ch_rlast_out), 64'(0));
`ifdef FRAME_DEMUX_STATS_EN
    chk("async_rst_fcnt", 64'(frame_cnt_out), 64'(0));
    chk("async_rst_dcnt", 64'(drop_cnt_out), 64'(0));
`endif
    rdy_mode = 0;
    repeat (2) @(negedge logic_clk);
    #1 logic_rstn = 1'b1;
    sync();
    clr();
    send_frame(3'b100, 6, 0, 1); drain();
    chk("post_rst_ch2_beats", 64'(hs_cnt[2]), 64'(6));
    chk("post_rst_ch1_beats", 64'(hs_cnt[1]), 64'(0));
    chk("post_rst_lasts", 64'(last_seen[2]), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
